// File: rtl/lcd_sequencer.sv
// HD44780-style LCD bring-up and refresh sequencer: runs the power-on nibble sequence,
// configures the panel, then streams two 16-character lines from an external buffer.
module lcd_sequencer #(
  parameter int unsigned POWERUP_CYC = 750000,
  parameter int unsigned INIT1_CYC   = 205000,
  parameter int unsigned INIT2_CYC   = 5000,
  parameter int unsigned CMD_CYC     = 2000,
  parameter int unsigned CLR_CYC     = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       busy,
  output logic       instruction_valid,
  output logic [9:0] instruction,
  output logic       init_mode,
  output logic [4:0] char_addr,
  input  logic [7:0] char_data,
  input  logic       refresh,
  output logic       ready
);

  localparam logic [19:0] PwrLast   = 20'(POWERUP_CYC - 1);
  localparam logic [19:0] Init1Last = 20'(INIT1_CYC - 1);
  localparam logic [19:0] Init2Last = 20'(INIT2_CYC - 1);
  localparam logic [19:0] CmdLast   = 20'(CMD_CYC - 1);
  localparam logic [19:0] ClrLast   = 20'(CLR_CYC - 1);

  // Steps 0-3 are init nibbles, 4-7 config, then line-address and character steps.
  localparam logic [3:0] StepLastInit = 4'd3;
  localparam logic [3:0] StepClear    = 4'd7;
  localparam logic [3:0] StepAddr     = 4'd8;
  localparam logic [3:0] StepChar     = 4'd9;

  typedef enum logic [2:0] {
    StPwrWait,
    StIssue,
    StWaitAck,
    StWaitDone,
    StDelay,
    StIdle
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [4:0]  idx_q, idx_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] delay_last;
  logic [9:0]  instr_q, instr_d;
  logic [9:0]  word;
  logic        pending_q, pending_d;
  logic        valid_q, valid_d;
  logic        init_q, init_d;
  logic        ready_q, ready_d;

  always_comb begin
    case (step_q)
      4'd0, 4'd1, 4'd2: word = 10'h003;
      4'd3:             word = 10'h002;
      4'd4:             word = 10'h028;
      4'd5:             word = 10'h006;
      4'd6:             word = 10'h00C;
      4'd7:             word = 10'h001;
      StepAddr:         word = idx_q[4] ? 10'h0C0 : 10'h080;
      default:          word = {2'b10, char_data};
    endcase
  end

  always_comb begin
    case (step_q)
      4'd0:      delay_last = Init1Last;
      4'd1:      delay_last = Init2Last;
      StepClear: delay_last = ClrLast;
      default:   delay_last = CmdLast;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    init_d    = init_q;
    pending_d = pending_q;
    valid_d   = 1'b0;

    if (refresh && state_q != StIdle) pending_d = 1'b1;

    case (state_q)
      StPwrWait: begin
        if (cnt_q == PwrLast) state_d = StIssue;
        else                  cnt_d   = cnt_q + 20'd1;
      end
      StIssue: begin
        if (!busy) begin
          valid_d = 1'b1;
          instr_d = word;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!busy) begin
          state_d = StDelay;
          cnt_d   = '0;
        end
      end
      StDelay: begin
        if (cnt_q != delay_last) begin
          cnt_d = cnt_q + 20'd1;
        end else begin
          state_d = StIssue;
          if (step_q == StepLastInit) init_d = 1'b0;
          if (step_q < StepAddr) begin
            // Clear Display rolls straight into the first frame.
            step_d = step_q + 4'd1;
            idx_d  = '0;
          end else if (step_q == StepAddr) begin
            step_d = StepChar;
          end else if (idx_q == 5'd31) begin
            state_d = StIdle;
          end else if (idx_q == 5'd15) begin
            idx_d  = 5'd16;
            step_d = StepAddr;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      StIdle: begin
        if (refresh || pending_q) begin
          pending_d = 1'b0;
          step_d    = StepAddr;
          idx_d     = '0;
          state_d   = StIssue;
        end
      end
      default: state_d = StPwrWait;
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StPwrWait;
      step_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      instr_q   <= '0;
      init_q    <= 1'b1;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      init_q    <= init_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  assign instruction_valid = valid_q;
  assign instruction       = instr_q;
  assign init_mode         = init_q;
  assign char_addr         = idx_q;
  assign ready             = ready_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Randomised bench for lcd_sequencer: an expected-instruction queue built from the display
// protocol, a busy-holding sender model, and one compare process on every falling edge.
module tb_lcd_sequencer;

  localparam int unsigned PwrCyc   = 50;
  localparam int unsigned Init1Cyc = 20;
  localparam int unsigned Init2Cyc = 10;
  localparam int unsigned CmdCyc   = 5;
  localparam int unsigned ClrCyc   = 30;
  localparam int BusyCyc = 8;
  // Strobe-to-strobe overhead beyond busy and delay: ack detect, done detect, issue register.
  localparam int HsLat   = 3;
  localparam int GapCmd  = BusyCyc + HsLat + int'(CmdCyc);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       refresh = 1'b0;
  logic       busy, instruction_valid, init_mode, ready;
  logic [9:0] instruction;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic [7:0] buf_mem [32];
  int         bcnt = 0;
  int         rcyc = 0;

  assign busy      = (bcnt != 0) || stall;
  assign char_data = buf_mem[char_addr];

  always #5 clk = ~clk;

  lcd_sequencer #(
    .POWERUP_CYC(PwrCyc),
    .INIT1_CYC  (Init1Cyc),
    .INIT2_CYC  (Init2Cyc),
    .CMD_CYC    (CmdCyc),
    .CLR_CYC    (ClrCyc)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .busy             (busy),
    .instruction_valid(instruction_valid),
    .instruction      (instruction),
    .init_mode        (init_mode),
    .char_addr        (char_addr),
    .char_data        (char_data),
    .refresh          (refresh),
    .ready            (ready)
  );

  // Sender: busy for BusyCyc cycles starting the cycle after each strobe.
  always @(posedge clk) begin
    if (instruction_valid)  bcnt <= BusyCyc;
    else if (bcnt != 0)     bcnt <= bcnt - 1;
  end

  always @(posedge clk) rcyc <= reset ? 0 : rcyc + 1;

  typedef struct {
    logic [9:0] word;
    logic       init;
    int         gap;       // 0: gap not predicted
    bit         may_idle;  // ready may be high while this is the next expected entry
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         ncyc = 0;
  int         last_t = 0;
  int         n_strobes = 0;
  bit         skip_gap = 1'b0;
  bit         want_first = 1'b0;
  logic       prev_valid = 1'b0;
  time        last_st_time = 0;
  logic [9:0] dut_log [512];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void push(input logic [9:0] w, input logic im, input int gap, input bit mi);
    exp_t x;
    x.word = w;
    x.init = im;
    x.gap = gap;
    x.may_idle = mi;
    exp_q.push_back(x);
  endfunction

  function automatic void push_init();
    push(10'h003, 1'b1, 0, 1'b0);
    push(10'h003, 1'b1, BusyCyc + HsLat + int'(Init1Cyc), 1'b0);
    push(10'h003, 1'b1, BusyCyc + HsLat + int'(Init2Cyc), 1'b0);
    push(10'h002, 1'b1, GapCmd, 1'b0);
    push(10'h028, 1'b0, GapCmd, 1'b0);
    push(10'h006, 1'b0, GapCmd, 1'b0);
    push(10'h00C, 1'b0, GapCmd, 1'b0);
    push(10'h001, 1'b0, GapCmd, 1'b0);
  endfunction

  function automatic void push_frame(input int first_gap, input bit mi);
    push(10'h080, 1'b0, first_gap, mi);
    for (int i = 0; i < 16; i++) push({2'b10, buf_mem[i]}, 1'b0, GapCmd, 1'b0);
    push(10'h0C0, 1'b0, GapCmd, 1'b0);
    for (int i = 16; i < 32; i++) push({2'b10, buf_mem[i]}, 1'b0, GapCmd, 1'b0);
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (!reset) begin
      chk("valid_while_busy", {31'd0, instruction_valid && busy}, 32'd0);
      if (instruction_valid) begin
        chk("strobe_width", {31'd0, prev_valid}, 32'd0);
        if (want_first) begin
          chk("first_strobe_cycle", rcyc, PwrCyc + 1);
          want_first = 1'b0;
        end
        if (n_strobes < 512) dut_log[n_strobes] = instruction;
        n_strobes++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {22'd0, instruction}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("instruction", {22'd0, instruction}, {22'd0, e.word});
          chk("init_mode", {31'd0, init_mode}, {31'd0, e.init});
          if (e.gap != 0 && !skip_gap) chk("strobe_gap", ncyc - last_t, e.gap);
        end
        skip_gap = 1'b0;
        last_t = ncyc;
        last_st_time = $time;
      end else if (exp_q.size() != 0 && !exp_q[0].may_idle) begin
        chk("ready_while_active", {31'd0, ready}, 32'd0);
      end
    end
    prev_valid = instruction_valid;
  end

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(ready === 1'b1 && exp_q.size() == 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {31'd0, n < max}, 32'd1);
  endtask

  task automatic wait_strobes(input int target, input int max);
    int n = 0;
    while (n_strobes < target && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_wait", {31'd0, n < max}, 32'd1);
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic quiet_idle(input int expect_strobes);
    repeat (60) @(negedge clk);
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_no_strobes", n_strobes, expect_strobes);
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", {31'd0, instruction_valid}, 32'd0);
    chk("rst_instruction", {22'd0, instruction}, 32'd0);
    chk("rst_init_mode", {31'd0, init_mode}, 32'd1);
    chk("rst_char_addr", {27'd0, char_addr}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
  endtask

  initial begin
    int   base;
    int   held;
    time  t_drop;

    for (int i = 0; i < 32; i++) buf_mem[i] = 8'h41 + 8'(i);

    // Power-up, configuration and the automatic first frame.
    repeat (3) @(negedge clk);
    check_reset_outputs();
    push_init();
    push_frame(BusyCyc + HsLat + int'(ClrCyc), 1'b0);
    want_first = 1'b1;
    reset = 1'b0;
    wait_idle(3000);
    chk("frame1_count", n_strobes, 42);
    chk("pin_first", {22'd0, dut_log[0]}, 32'h003);
    chk("pin_nibble2", {22'd0, dut_log[3]}, 32'h002);
    chk("pin_config", {22'd0, dut_log[4]}, 32'h028);
    chk("pin_clear", {22'd0, dut_log[7]}, 32'h001);
    chk("pin_line1", {22'd0, dut_log[8]}, 32'h080);
    chk("pin_char0", {22'd0, dut_log[9]}, 32'h241);
    chk("pin_line2", {22'd0, dut_log[25]}, 32'h0C0);
    chk("pin_char16", {22'd0, dut_log[26]}, 32'h251);
    chk("pin_char31", {22'd0, dut_log[41]}, 32'h260);
    quiet_idle(42);

    // Refresh from IDLE with random buffer contents.
    for (int i = 0; i < 32; i++) buf_mem[i] = 8'($urandom);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    base = n_strobes;
    push_frame(0, 1'b1);
    pulse_refresh();
    wait_idle(1500);
    chk("refresh_frame_len", n_strobes - base, 34);

    // Three mid-frame refreshes collapse into one extra frame.
    base = n_strobes;
    push_frame(0, 1'b1);
    push_frame(GapCmd + 1, 1'b1);
    pulse_refresh();
    wait_strobes(base + int'($urandom_range(2, 10)), 1000);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(1, 30)) @(negedge clk);
      pulse_refresh();
    end
    wait_idle(3000);
    chk("pending_frames_len", n_strobes - base, 68);
    quiet_idle(base + 68);

    // Busy held high while the sequencer sits in ISSUE.
    base = n_strobes;
    push_frame(0, 1'b1);
    pulse_refresh();
    wait_strobes(base + int'($urandom_range(2, 30)), 1000);
    repeat (11) @(negedge clk);
    stall = 1'b1;
    skip_gap = 1'b1;
    held = n_strobes;
    repeat (100) @(negedge clk);
    chk("stall_no_strobe", n_strobes, held);
    stall = 1'b0;
    t_drop = $time;
    repeat (10) @(negedge clk);
    chk("stall_one_strobe", n_strobes, held + 1);
    chk("stall_release_lat", 32'((last_st_time - t_drop) / 10), 32'd1);
    wait_idle(1500);
    chk("stall_frame_len", n_strobes - base, 34);

    // Reset during character 10 with a refresh pending.
    base = n_strobes;
    push_frame(0, 1'b1);
    pulse_refresh();
    wait_strobes(base + 3, 1000);
    pulse_refresh();
    wait_strobes(base + 12, 1000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    exp_q.delete();
    push_init();
    push_frame(BusyCyc + HsLat + int'(ClrCyc), 1'b0);
    base = n_strobes;
    want_first = 1'b1;
    reset = 1'b0;
    wait_idle(3000);
    chk("post_reset_count", n_strobes - base, 42);
    quiet_idle(base + 42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
